// File: rtl/dct_quant_pkg.sv
// dct_quant_pkg: shared constants, sideband type and saturation helper for
// the DCT quantizer.
package dct_quant_pkg;
  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int RECIP_ONE = 65536;    // R for Q=1 (unity gain)
  localparam int RND       = 1 << 15;  // half LSB of the 2^16 fixed-point scale

  typedef struct packed {
    logic eob;
    logic sob;
    logic sof;
  } sb_t;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction
endpackage

// File: rtl/dct_quant_lane.sv
// dct_quant_lane: one column of the quantizer datapath.
//   S1: |x|, sign capture, register reciprocal
//   S2: mag * R
//   S3: round half away from zero, re-apply sign, saturate
// Ports: clk, rst_n, x (signed coefficient), r (reciprocal), y (quantized).
module dct_quant_lane
  import dct_quant_pkg::*;
#(
  parameter int W_I = 16,
  parameter int W_O = 12,
  parameter int W_R = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W_I-1:0] x,
  input  logic [W_R-1:0] r,
  output logic [W_O-1:0] y
);
  localparam int PW = W_I + 1 + W_R;

  logic [W_I:0]         mag_q, mag_d;
  logic                 neg_q, neg_d;
  logic [W_R-1:0]       r_q, r_d;
  logic [PW-1:0]        p_q, p_d;
  logic                 neg2_q, neg2_d;
  logic [W_O-1:0]       y_q, y_d;
  logic signed [W_I:0]  xs;
  logic [PW:0]          sum;
  logic [PW-16:0]       q;
  logic signed [31:0]   res;

  always_comb begin
    // One extra bit so the most negative input has an exact magnitude.
    xs     = {x[W_I-1], x};
    neg_d  = x[W_I-1];
    mag_d  = neg_d ? $unsigned(-xs) : $unsigned(xs);
    r_d    = r;
    p_d    = PW'(mag_q) * PW'(r_q);
    neg2_d = neg_q;
    // Rounding on the magnitude gives round-half-away-from-zero after sign.
    sum    = {1'b0, p_q} + (PW+1)'(RND);
    q      = (PW-15)'(sum >> 16);
    res    = neg2_q ? -$signed(32'(q)) : $signed(32'(q));
    y_d    = W_O'(sat_w(res, W_O));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= '0;
      neg_q  <= 1'b0;
      r_q    <= '0;
      p_q    <= '0;
      neg2_q <= 1'b0;
      y_q    <= '0;
    end else begin
      mag_q  <= mag_d;
      neg_q  <= neg_d;
      r_q    <= r_d;
      p_q    <= p_d;
      neg2_q <= neg2_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;
endmodule

// File: rtl/dct_quant.sv
// dct_quant: row-parallel quantizer behind the forward DCT.
// Inputs : in_valid/in_data (8 coefficients per row) with sob/eob/sof
//          sideband; tbl_we/tbl_addr/tbl_data write the shadow reciprocal
//          bank; tbl_commit arms a bank swap at the next accepted sof beat.
// Outputs: out_valid/out_data/out_sob/out_eob/out_sof 3 cycles after input;
//          proto_err pulses one cycle after a framing violation.
module dct_quant
  import dct_quant_pkg::*;
#(
  parameter int W_I = 16,
  parameter int W_O = 12,
  parameter int W_R = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0][W_I-1:0]   in_data,
  input  logic                  in_sob,
  input  logic                  in_eob,
  input  logic                  in_sof,
  input  logic                  tbl_we,
  input  logic [5:0]            tbl_addr,
  input  logic [W_R-1:0]        tbl_data,
  input  logic                  tbl_commit,
  output logic                  out_valid,
  output logic [7:0][W_O-1:0]   out_data,
  output logic                  out_sob,
  output logic                  out_eob,
  output logic                  out_sof,
  output logic                  proto_err
);
  localparam int STAGES = 3;

  logic [W_R-1:0]             bank_q [2][ROWS*COLS];
  logic [W_R-1:0]             bank_d [2][ROWS*COLS];
  logic                       act_q, act_d;
  logic                       pend_q, pend_d;
  logic [2:0]                 row_q, row_d;
  logic                       err_q, err_d;
  logic [STAGES:1]            vld_pipe_q, vld_pipe_d;
  sb_t  [STAGES:1]            sb_pipe_q, sb_pipe_d;
  sb_t                        sb_in;
  logic [2:0]                 used_row;
  logic                       swap;
  logic [COLS-1:0][W_R-1:0]   rcp;
  logic [COLS-1:0][W_O-1:0]   lane_y;

  always_comb begin
    used_row = in_sob ? 3'd0 : row_q;
    swap     = in_valid & in_sof & pend_q;
    // The swapping beat already reads the new bank.
    act_d    = act_q ^ swap;
    // A commit coinciding with the swap re-arms for the following sof.
    pend_d   = (pend_q & ~swap) | tbl_commit;
    row_d    = row_q;
    if (in_valid) row_d = in_eob ? 3'd0 : used_row + 3'd1;
    err_d    = in_valid & ((in_sob & (row_q != 3'd0)) |
                           (in_eob & (used_row != 3'd7)) |
                           (in_sof & ~in_sob));
    bank_d   = bank_q;
    if (tbl_we) bank_d[!act_d][tbl_addr] = tbl_data;
    for (int i = 0; i < COLS; i++) rcp[i] = bank_q[act_d][{used_row, i[2:0]}];
    sb_in      = in_valid ? '{eob: in_eob, sob: in_sob, sof: in_sof} : '0;
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
    sb_pipe_d  = {sb_pipe_q[STAGES-1:1], sb_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < ROWS*COLS; a++) bank_q[b][a] <= W_R'(RECIP_ONE);
      act_q      <= 1'b0;
      pend_q     <= 1'b0;
      row_q      <= 3'd0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
      sb_pipe_q  <= '0;
    end else begin
      bank_q     <= bank_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      row_q      <= row_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
      sb_pipe_q  <= sb_pipe_d;
    end
  end

  for (genvar i = 0; i < COLS; i++) begin : g_lane
    dct_quant_lane #(.W_I(W_I), .W_O(W_O), .W_R(W_R)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (in_data[i]),
      .r     (rcp[i]),
      .y     (lane_y[i])
    );
  end

  assign out_data  = lane_y;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_sob   = sb_pipe_q[STAGES].sob;
  assign out_eob   = sb_pipe_q[STAGES].eob;
  assign out_sof   = sb_pipe_q[STAGES].sof;
  assign proto_err = err_q;
endmodule

// File: tb/tb_dct_quant.sv
module tb_dct_quant;
  localparam int W_I = 16, W_O = 12, W_R = 17;

  logic                clk = 1'b0, rst_n = 1'b0;
  logic                in_valid = 1'b0, in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0;
  logic [7:0][W_I-1:0] in_data = '0;
  logic                tbl_we = 1'b0, tbl_commit = 1'b0;
  logic [5:0]          tbl_addr = '0;
  logic [W_R-1:0]      tbl_data = '0;
  logic                out_valid, out_sob, out_eob, out_sof, proto_err;
  logic [7:0][W_O-1:0] out_data;

  dct_quant #(.W_I(W_I), .W_O(W_O), .W_R(W_R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_commit(tbl_commit),
    .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob),
    .out_eob(out_eob), .out_sof(out_sof), .proto_err(proto_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][W_O-1:0] d;
    logic                sob, eob, sof;
    int                  cyc;
  } beat_t;

  beat_t exp_q[$], obs_q[$];
  bit    pe_exp[$], pe_obs[$];
  int    cyc = 0;
  int    nvec = 0, nerr = 0;
  // Reference state: two reciprocal tables, active index, pending flag, row.
  int    mtab[2][64];
  int    mact, mpend, mrow;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      beat_t b;
      b.d = out_data; b.sob = out_sob; b.eob = out_eob; b.sof = out_sof; b.cyc = cyc;
      obs_q.push_back(b);
    end
  end

  // Division by Q via reciprocal, rounded half away from zero, clamped.
  function automatic int qref(int x, int r);
    longint mag, q, v;
    mag = (x < 0) ? -x : x;
    q   = (mag * r + 32768) >>> 16;
    v   = (x < 0) ? -q : q;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) for (int a = 0; a < 64; a++) mtab[b][a] = 65536;
    mact = 0; mpend = 0; mrow = 0;
  endtask

  // Apply one cycle of stimulus (called at a falling edge) and advance the model.
  task automatic drive(input bit v, input logic [7:0][W_I-1:0] d, input bit sob, input bit eob,
                       input bit sof, input bit cm, input bit we, input logic [5:0] a,
                       input logic [W_R-1:0] td);
    int used; bit err; beat_t e;
    in_valid = v; in_data = d; in_sob = sob; in_eob = eob; in_sof = sof;
    tbl_commit = cm; tbl_we = we; tbl_addr = a; tbl_data = td;
    used = sob ? 0 : mrow;
    err  = v && ((sob && mrow != 0) || (eob && used != 7) || (sof && !sob));
    if (v) begin
      if (sof && mpend) begin mact ^= 1; mpend = 0; end
      for (int i = 0; i < 8; i++)
        e.d[i] = W_O'(qref(int'($signed(d[i])), mtab[mact][used*8+i]));
      e.sob = sob; e.eob = eob; e.sof = sof; e.cyc = cyc + 3;
      exp_q.push_back(e);
      mrow = eob ? 0 : (used + 1) % 8;
    end
    pe_exp.push_back(err);
    if (cm) mpend = 1;
    if (we) mtab[mact ^ 1][a] = int'(td);
    @(negedge clk);
    pe_obs.push_back(proto_err);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, '0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  function automatic logic [7:0][W_I-1:0] mkrow(input int mode);
    int pa[8] = '{100, -100, 0, 1, -1, 32767, -32768, 5};
    int pb[8] = '{40, -40, 24, 7, 40, -40, 24, 7};
    logic [7:0][W_I-1:0] d;
    for (int i = 0; i < 8; i++) begin
      if (mode == 1) d[i] = W_I'(pa[i]);
      else if (mode == 2) d[i] = W_I'(pb[i]);
      else case ($urandom_range(0, 5))
        0: d[i] = 16'h8000;
        1: d[i] = 16'h7fff;
        2: d[i] = W_I'($urandom_range(0, 64)) - 16'd32;
        default: d[i] = W_I'($urandom);
      endcase
    end
    return d;
  endfunction

  task automatic send_block(input bit sof, input bit cm0, input int mode);
    for (int r = 0; r < 8; r++)
      drive(1, mkrow(mode), r == 0, r == 7, sof && r == 0, cm0 && r == 0, 0, '0, '0);
  endtask

  task automatic program_shadow(input int fixed_r);
    for (int a = 0; a < 64; a++)
      drive(0, '0, 0, 0, 0, 0, 1, 6'(a),
            W_R'(fixed_r != 0 ? fixed_r : int'($urandom_range(600, 131071))));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec += 3;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin nerr++; $display("FAIL reset_data: got %h want 0", out_data); end
    if ({out_sob, out_eob, out_sof, proto_err} !== 4'b0) begin
      nerr++; $display("FAIL reset_side: got %b want 0000", {out_sob, out_eob, out_sof, proto_err});
    end
    rst_n = 1'b1;
    model_reset();
    idle(2);
    nvec++;
    if (out_valid !== 1'b0 || proto_err !== 1'b0) begin
      nerr++; $display("FAIL idle_after_reset: valid %b err %b want 0 0", out_valid, proto_err);
    end
  endtask

  task automatic test_passthru();
    beat_t e, o; logic [7:0][W_O-1:0] want;
    int sat[8] = '{100, -100, 0, 1, -1, 2047, -2048, 5};
    for (int i = 0; i < 8; i++) want[i] = W_O'(sat[i]);
    send_block(0, 0, 1);
    idle(5);
    nvec++;
    if (obs_q.size() == 0 || obs_q[0].d !== want) begin
      nerr++; $display("FAIL passthru_const: got %h want %h", obs_q.size() ? obs_q[0].d : '0, want);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL passthru: missing beat want %h", e.d); end
      else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || {o.sob, o.eob, o.sof} !== {e.sob, e.eob, e.sof} || o.cyc != e.cyc) begin
          nerr++; $display("FAIL passthru: got %h %b%b%b @%0d want %h %b%b%b @%0d",
                           o.d, o.sob, o.eob, o.sof, o.cyc, e.d, e.sob, e.eob, e.sof, e.cyc);
        end
      end
    end
    nvec++;
    if (obs_q.size() != 0) begin nerr++; $display("FAIL passthru_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_q16();
    beat_t e, o; logic [7:0][W_O-1:0] want;
    int ex[8] = '{3, -3, 2, 0, 3, -3, 2, 0};
    for (int i = 0; i < 8; i++) want[i] = W_O'(ex[i]);
    program_shadow(4096);
    drive(0, '0, 0, 0, 0, 1, 0, '0, '0);
    send_block(1, 0, 2);
    idle(5);
    nvec++;
    if (obs_q.size() == 0 || obs_q[0].d !== want) begin
      nerr++; $display("FAIL q16_const: got %h want %h", obs_q.size() ? obs_q[0].d : '0, want);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL q16: missing beat want %h", e.d); end
      else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || {o.sob, o.eob, o.sof} !== {e.sob, e.eob, e.sof} || o.cyc != e.cyc) begin
          nerr++; $display("FAIL q16: got %h @%0d want %h @%0d", o.d, o.cyc, e.d, e.cyc);
        end
      end
    end
  endtask

  task automatic test_commit_midframe();
    beat_t e, o;
    program_shadow(0);
    drive(0, '0, 0, 0, 0, 1, 0, '0, '0);
    send_block(0, 0, 0);
    send_block(0, 0, 0);
    send_block(1, 0, 0);
    idle(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL midframe: missing beat want %h", e.d); end
      else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || {o.sob, o.eob, o.sof} !== {e.sob, e.eob, e.sof} || o.cyc != e.cyc) begin
          nerr++; $display("FAIL midframe: got %h @%0d want %h @%0d", o.d, o.cyc, e.d, e.cyc);
        end
      end
    end
  endtask

  task automatic test_commit_same_sof();
    beat_t e, o;
    program_shadow(0);
    send_block(1, 1, 0);
    send_block(1, 0, 0);
    idle(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL same_sof: missing beat want %h", e.d); end
      else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || {o.sob, o.eob, o.sof} !== {e.sob, e.eob, e.sof} || o.cyc != e.cyc) begin
          nerr++; $display("FAIL same_sof: got %h @%0d want %h @%0d", o.d, o.cyc, e.d, e.cyc);
        end
      end
    end
  endtask

  task automatic test_proto();
    beat_t e, o; bit pe, po;
    pe_exp.delete(); pe_obs.delete();
    // Nine rows, eob only on the ninth (wrapped to row 0).
    for (int r = 0; r < 9; r++) drive(1, mkrow(0), r == 0, r == 8, 0, 0, 0, '0, '0);
    // sob arriving while the counter sits at row 3.
    for (int r = 0; r < 3; r++) drive(1, mkrow(0), r == 0, 0, 0, 0, 0, '0, '0);
    for (int r = 0; r < 8; r++) drive(1, mkrow(0), r == 0, r == 7, 0, 0, 0, '0, '0);
    // sof without sob, then a block whose sob lands on row 1.
    drive(1, mkrow(0), 0, 0, 1, 0, 0, '0, '0);
    send_block(0, 0, 0);
    idle(5);
    while (pe_exp.size() > 0) begin
      pe = pe_exp.pop_front(); po = pe_obs.pop_front(); nvec++;
      if (po !== pe) begin nerr++; $display("FAIL proto_err: got %b want %b", po, pe); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL proto_data: missing beat want %h", e.d); end
      else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || {o.sob, o.eob, o.sof} !== {e.sob, e.eob, e.sof} || o.cyc != e.cyc) begin
          nerr++; $display("FAIL proto_data: got %h @%0d want %h @%0d", o.d, o.cyc, e.d, e.cyc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t e, o;
    for (int r = 0; r < 4; r++) drive(1, mkrow(0), r == 0, 0, 0, 0, 0, '0, '0);
    in_valid = 1'b1; in_data = mkrow(0); in_sob = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    nvec += 2;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      nerr++; $display("FAIL reset_mid_out: valid %b data %h want 0 0", out_valid, out_data);
    end
    if (proto_err !== 1'b0 || out_sob !== 1'b0) begin
      nerr++; $display("FAIL reset_mid_side: err %b sob %b want 0 0", proto_err, out_sob);
    end
    in_valid = 1'b0;
    exp_q.delete(); obs_q.delete(); pe_exp.delete(); pe_obs.delete();
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    send_block(1, 0, 0);
    idle(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL reset_mid: missing beat want %h", e.d); end
      else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || {o.sob, o.eob, o.sof} !== {e.sob, e.eob, e.sof} || o.cyc != e.cyc) begin
          nerr++; $display("FAIL reset_mid: got %h @%0d want %h @%0d", o.d, o.cyc, e.d, e.cyc);
        end
      end
    end
  endtask

  task automatic test_random();
    beat_t e, o; bit pe, po;
    pe_exp.delete(); pe_obs.delete();
    for (int b = 0; b < 12; b++) begin
      bit sof = ($urandom_range(0, 2) == 0);
      for (int r = 0; r < 8; r++) begin
        drive(1, mkrow(0), r == 0, r == 7, sof && r == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 1), 6'($urandom), W_R'($urandom_range(600, 131071)));
        if ($urandom_range(0, 4) == 0) idle(1);
      end
    end
    idle(5);
    while (pe_exp.size() > 0) begin
      pe = pe_exp.pop_front(); po = pe_obs.pop_front(); nvec++;
      if (po !== pe) begin nerr++; $display("FAIL random_err: got %b want %b", po, pe); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL random: missing beat want %h", e.d); end
      else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || {o.sob, o.eob, o.sof} !== {e.sob, e.eob, e.sof} || o.cyc != e.cyc) begin
          nerr++; $display("FAIL random: got %h @%0d want %h @%0d", o.d, o.cyc, e.d, e.cyc);
        end
      end
    end
    nvec++;
    if (obs_q.size() != 0) begin nerr++; $display("FAIL random_extra: got %0d want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_q16();
    test_commit_midframe();
    test_commit_same_sof();
    test_proto();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
